mor1kx_wb_order_marocchino: RTL and testbench

In-order write-back collector for the MAROCCHINO pipeline. It sits between the execution units and the register file. DECODE records each dispatched instruction's unit id and destination in an order FIFO. The block then retires unit results strictly in dispatch order, and drives the write-back bus (flag, address, result and a 1-clock new-result strobe) that the register file uses for GPR writes and operand bypassing.

---
 rtl/mor1kx_wb_order_marocchino.sv | 141 ++++++++++++++
 tb/tb_mor1kx_wb_order_marocchino.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_wb_order_marocchino.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_wb_order_marocchino
// Purpose  : In-order write-back collector for the MAROCCHINO pipeline.
//            DECODE pushes {unit, rf_wb, rfd_adr} for every dispatched
//            instruction into an order FIFO. Unit results are retired
//            strictly in dispatch order. Each retirement is registered onto
//            the write-back bus used for GPR writes and operand bypassing.
// Ports    :
//   clk, rst_n            clock / synchronous active-low reset
//   pipeline_flush_i      drop every pending order entry
//   padv_decode_i         dispatch strobe (push one entry)
//   dcod_unit_i           0 ALU, 1 MUL, 2 DIV, 3 LSU
//   dcod_rf_wb_i          instruction writes a GPR
//   dcod_rfd_adr_i        destination GPR
//   order_full_o          FIFO full, DECODE must stall
//   order_empty_o         no pending entries
//   exec_valid_i          per-unit result ready (bit = unit id)
//   exec_result_i         per-unit results, unit k at [k*W +: W]
//   exec_ack_o            per-unit result consumed (combinational, one-hot/0)
//   wb_rf_wb_o            last retired instruction writes a GPR
//   wb_rfd_adr_o          last retired destination
//   wb_result_o           last retired result
//   wb_new_result_o       one-cycle strobe: wb_* updated this cycle
// Revision : 1.0 - initial release
// ============================================================================
module mor1kx_wb_order_marocchino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int ORDER_DEPTH          = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pipeline_flush_i,
  input  logic                              padv_decode_i,
  input  logic [1:0]                        dcod_unit_i,
  input  logic                              dcod_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]   dcod_rfd_adr_i,
  output logic                              order_full_o,
  output logic                              order_empty_o,
  input  logic [3:0]                        exec_valid_i,
  input  logic [4*OPTION_OPERAND_WIDTH-1:0] exec_result_i,
  output logic [3:0]                        exec_ack_o,
  output logic                              wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]   wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   wb_result_o,
  output logic                              wb_new_result_o
);

  localparam int PTR_W = $clog2(ORDER_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ORDER_DEPTH);

  // Order FIFO storage, split per field.
  logic [1:0]                      unit_mem [ORDER_DEPTH];
  logic                            rfwb_mem [ORDER_DEPTH];
  logic [OPTION_RF_ADDR_WIDTH-1:0] adr_mem  [ORDER_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [1:0]                      head_unit;
  logic                            head_rf_wb;
  logic [OPTION_RF_ADDR_WIDTH-1:0] head_adr;
  logic [OPTION_OPERAND_WIDTH-1:0] head_result;
  logic                            push;
  logic                            commit;

  // Full/empty decode the registered count, so a pop in the same cycle
  // never opens room for a push while full.
  assign order_full_o  = (count == FULL_CNT);
  assign order_empty_o = (count == '0);

  assign head_unit  = unit_mem[rd_ptr];
  assign head_rf_wb = rfwb_mem[rd_ptr];
  assign head_adr   = adr_mem[rd_ptr];

  assign push   = padv_decode_i & ~order_full_o & ~pipeline_flush_i;
  assign commit = ~order_empty_o & exec_valid_i[head_unit] & ~pipeline_flush_i;

  // Only the head unit can ever be acknowledged; others keep holding valid.
  assign exec_ack_o = commit ? (4'b0001 << head_unit) : 4'b0000;

  always_comb begin
    head_result = exec_result_i[0 +: OPTION_OPERAND_WIDTH];
    case (head_unit)
      2'd0:    head_result = exec_result_i[0*OPTION_OPERAND_WIDTH +: OPTION_OPERAND_WIDTH];
      2'd1:    head_result = exec_result_i[1*OPTION_OPERAND_WIDTH +: OPTION_OPERAND_WIDTH];
      2'd2:    head_result = exec_result_i[2*OPTION_OPERAND_WIDTH +: OPTION_OPERAND_WIDTH];
      default: head_result = exec_result_i[3*OPTION_OPERAND_WIDTH +: OPTION_OPERAND_WIDTH];
    endcase
  end

  // FIFO payload needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      unit_mem[wr_ptr] <= dcod_unit_i;
      rfwb_mem[wr_ptr] <= dcod_rf_wb_i;
      adr_mem[wr_ptr]  <= dcod_rfd_adr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      wb_rf_wb_o      <= 1'b0;
      wb_rfd_adr_o    <= '0;
      wb_result_o     <= '0;
      wb_new_result_o <= 1'b0;
    end else if (pipeline_flush_i) begin
      // Address and result hold so the bypass network sees stable data;
      // only the write enable and strobe are dropped.
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      wb_rf_wb_o      <= 1'b0;
      wb_new_result_o <= 1'b0;
    end else begin
      wb_new_result_o <= commit;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (commit) begin
        rd_ptr       <= rd_ptr + 1'b1;
        wb_rf_wb_o   <= head_rf_wb;
        wb_rfd_adr_o <= head_adr;
        wb_result_o  <= head_result;
      end
      case ({push, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_wb_order_marocchino.sv
`default_nettype none
// ============================================================================
// Module   : tb_mor1kx_wb_order_marocchino
// Purpose  : Directed self-checking bench for the in-order write-back
//            collector: reset, single ALU retire, reordering, full/wrap,
//            push blocked at full during a pop, and flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mor1kx_wb_order_marocchino;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          pipeline_flush;
  logic          padv_decode;
  logic [1:0]    dcod_unit;
  logic          dcod_rf_wb;
  logic [AW-1:0] dcod_rfd_adr;
  logic          order_full;
  logic          order_empty;
  logic [3:0]    exec_valid;
  logic [4*W-1:0] exec_result;
  logic [3:0]    exec_ack;
  logic          wb_rf_wb;
  logic [AW-1:0] wb_rfd_adr;
  logic [W-1:0]  wb_result;
  logic          wb_new_result;

  int checks   = 0;
  int failures = 0;

  mor1kx_wb_order_marocchino #(
    .OPTION_OPERAND_WIDTH (W),
    .OPTION_RF_ADDR_WIDTH (AW),
    .ORDER_DEPTH          (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipeline_flush_i (pipeline_flush),
    .padv_decode_i    (padv_decode),
    .dcod_unit_i      (dcod_unit),
    .dcod_rf_wb_i     (dcod_rf_wb),
    .dcod_rfd_adr_i   (dcod_rfd_adr),
    .order_full_o     (order_full),
    .order_empty_o    (order_empty),
    .exec_valid_i     (exec_valid),
    .exec_result_i    (exec_result),
    .exec_ack_o       (exec_ack),
    .wb_rf_wb_o       (wb_rf_wb),
    .wb_rfd_adr_o     (wb_rfd_adr),
    .wb_result_o      (wb_result),
    .wb_new_result_o  (wb_new_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive just after the active edge, sample at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pipeline_flush = 1'b0;
    padv_decode    = 1'b0;
    dcod_unit      = 2'd0;
    dcod_rf_wb     = 1'b0;
    dcod_rfd_adr   = '0;
    exec_valid     = 4'b0000;
    exec_result    = '0;
  endtask

  task automatic dispatch(input logic [1:0] unit, input logic rfwb, input logic [AW-1:0] adr);
    padv_decode  = 1'b1;
    dcod_unit    = unit;
    dcod_rf_wb   = rfwb;
    dcod_rfd_adr = adr;
  endtask

  task automatic random_inputs();
    pipeline_flush = 1'($urandom);
    padv_decode    = 1'($urandom);
    dcod_unit      = 2'($urandom);
    dcod_rf_wb     = 1'($urandom);
    dcod_rfd_adr   = AW'($urandom);
    exec_valid     = 4'($urandom);
    exec_result    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  int exp_adr [8] = '{11, 12, 13, 14, 15, 16, 17, 20};

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // ---------------- reset with random inputs ----------------
    cyc(); random_inputs();
    smp(); chk("rst_ack_c1", 64'(exec_ack), 64'h0);
    cyc(); random_inputs();
    smp();
    chk("rst_ack_c2", 64'(exec_ack), 64'h0);
    chk("rst_empty", 64'(order_empty), 64'h1);
    chk("rst_full", 64'(order_full), 64'h0);
    chk("rst_rf_wb", 64'(wb_rf_wb), 64'h0);
    chk("rst_adr", 64'(wb_rfd_adr), 64'h0);
    chk("rst_result", 64'(wb_result), 64'h0);
    chk("rst_new", 64'(wb_new_result), 64'h0);
    cyc(); rst_n = 1'b1; idle_inputs();

    // ---------------- single ALU op ----------------
    cyc(); dispatch(2'd0, 1'b1, 5'd3);
    smp(); chk("alu_empty_before", 64'(order_empty), 64'h1);
    cyc(); idle_inputs(); exec_valid = 4'b0001; exec_result[0*W +: W] = 32'h1234_5678;
    smp();
    chk("alu_ack", 64'(exec_ack), 64'h1);
    chk("alu_not_empty", 64'(order_empty), 64'h0);
    cyc(); idle_inputs();
    smp();
    chk("alu_new", 64'(wb_new_result), 64'h1);
    chk("alu_adr", 64'(wb_rfd_adr), 64'h3);
    chk("alu_result", 64'(wb_result), 64'h1234_5678);
    chk("alu_rf_wb", 64'(wb_rf_wb), 64'h1);
    chk("alu_empty_after", 64'(order_empty), 64'h1);
    chk("alu_ack_drop", 64'(exec_ack), 64'h0);
    cyc();
    smp();
    chk("alu_new_drop", 64'(wb_new_result), 64'h0);
    chk("alu_adr_hold", 64'(wb_rfd_adr), 64'h3);
    chk("alu_result_hold", 64'(wb_result), 64'h1234_5678);

    // ---------------- reordering: DIV then ALU ----------------
    cyc(); dispatch(2'd2, 1'b1, 5'd5);
    cyc(); dispatch(2'd0, 1'b0, 5'd6); exec_valid = 4'b0001; exec_result[0*W +: W] = 32'hA;
    smp(); chk("ord_no_alu_ack", 64'(exec_ack), 64'h0);
    for (int i = 0; i < 9; i++) begin
      cyc(); padv_decode = 1'b0;
      smp(); chk("ord_wait_ack", 64'(exec_ack), 64'h0);
    end
    cyc(); exec_valid = 4'b0101; exec_result[2*W +: W] = 32'hB;
    smp(); chk("ord_div_ack", 64'(exec_ack), 64'h4);
    cyc();
    smp();
    chk("ord_alu_ack", 64'(exec_ack), 64'h1);
    chk("ord_div_new", 64'(wb_new_result), 64'h1);
    chk("ord_div_adr", 64'(wb_rfd_adr), 64'h5);
    chk("ord_div_result", 64'(wb_result), 64'hB);
    chk("ord_div_rf_wb", 64'(wb_rf_wb), 64'h1);
    cyc(); exec_valid = 4'b0000;
    smp();
    chk("ord_alu_new", 64'(wb_new_result), 64'h1);
    chk("ord_alu_adr", 64'(wb_rfd_adr), 64'h6);
    chk("ord_alu_result", 64'(wb_result), 64'hA);
    chk("ord_alu_rf_wb", 64'(wb_rf_wb), 64'h0);
    chk("ord_empty", 64'(order_empty), 64'h1);
    cyc();
    smp(); chk("ord_new_drop", 64'(wb_new_result), 64'h0);

    // ---------------- full / wrap ----------------
    for (int i = 0; i < 8; i++) begin
      cyc(); dispatch(2'd1, 1'b1, AW'(10 + i));
    end
    cyc(); dispatch(2'd1, 1'b1, 5'd18);   // 9th dispatch while full
    smp(); chk("full_after_8", 64'(order_full), 64'h1);
    cyc(); padv_decode = 1'b0;
    smp();
    chk("full_hold", 64'(order_full), 64'h1);
    chk("full_not_empty", 64'(order_empty), 64'h0);

    // Pop while full with a push attempt: push must be blocked.
    cyc(); dispatch(2'd1, 1'b1, 5'd19); exec_valid = 4'b0010; exec_result[1*W +: W] = 32'h300;
    smp();
    chk("pp_ack", 64'(exec_ack), 64'h2);
    chk("pp_full", 64'(order_full), 64'h1);
    cyc(); dispatch(2'd1, 1'b1, 5'd20); exec_valid = 4'b0000;
    smp();
    chk("pp_not_full", 64'(order_full), 64'h0);
    chk("pp_new", 64'(wb_new_result), 64'h1);
    chk("pp_adr", 64'(wb_rfd_adr), 64'd10);
    chk("pp_result", 64'(wb_result), 64'h300);
    cyc(); padv_decode = 1'b0;
    smp(); chk("pp_refull", 64'(order_full), 64'h1);

    // Drain across the pointer wrap; order must be 11..17 then 20.
    for (int i = 0; i < 8; i++) begin
      cyc(); exec_valid = 4'b0010; exec_result[1*W +: W] = 32'(32'h200 + i);
      smp();
      chk("drain_ack", 64'(exec_ack), 64'h2);
      if (i > 0) begin
        chk("drain_adr", 64'(wb_rfd_adr), 64'(exp_adr[i-1]));
        chk("drain_result", 64'(wb_result), 64'(32'h200 + i - 1));
        chk("drain_new", 64'(wb_new_result), 64'h1);
      end
    end
    cyc(); exec_valid = 4'b0000;
    smp();
    chk("drain_last_adr", 64'(wb_rfd_adr), 64'd20);
    chk("drain_last_result", 64'(wb_result), 64'h207);
    chk("drain_last_new", 64'(wb_new_result), 64'h1);
    chk("drain_empty", 64'(order_empty), 64'h1);

    // ---------------- flush ----------------
    for (int i = 0; i < 3; i++) begin
      cyc(); dispatch(2'd3, 1'b1, AW'(7 + i));
    end
    cyc(); dispatch(2'd3, 1'b1, 5'd25); pipeline_flush = 1'b1;
    exec_valid = 4'b1000; exec_result[3*W +: W] = 32'hDEAD;
    smp();
    chk("fl_ack", 64'(exec_ack), 64'h0);
    chk("fl_new", 64'(wb_new_result), 64'h0);
    chk("fl_not_empty", 64'(order_empty), 64'h0);
    cyc(); pipeline_flush = 1'b0; padv_decode = 1'b0;
    smp();
    chk("fl_empty", 64'(order_empty), 64'h1);
    chk("fl_rf_wb", 64'(wb_rf_wb), 64'h0);
    chk("fl_new_after", 64'(wb_new_result), 64'h0);
    chk("fl_ack_after", 64'(exec_ack), 64'h0);
    chk("fl_adr_hold", 64'(wb_rfd_adr), 64'd20);
    chk("fl_result_hold", 64'(wb_result), 64'h207);
    cyc();
    smp();
    chk("fl_still_empty", 64'(order_empty), 64'h1);
    chk("fl_still_no_new", 64'(wb_new_result), 64'h0);

    // ---------------- normal operation after flush ----------------
    cyc(); idle_inputs(); dispatch(2'd0, 1'b1, 5'd4);
    cyc(); idle_inputs(); exec_valid = 4'b0001; exec_result[0*W +: W] = 32'h55;
    smp(); chk("post_ack", 64'(exec_ack), 64'h1);
    cyc(); idle_inputs();
    smp();
    chk("post_new", 64'(wb_new_result), 64'h1);
    chk("post_adr", 64'(wb_rfd_adr), 64'h4);
    chk("post_result", 64'(wb_result), 64'h55);
    chk("post_rf_wb", 64'(wb_rf_wb), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
